// File: rtl/piezo_seq.sv
// Piezo warning sequencer: three prioritised request patterns played as 4-step tone sequences.
// Optional macro PIEZO_BATT_LATCH_EN makes the battery-low request sticky until reset.
module piezo_seq #(
  parameter int NOTE_CYC = 8388608,
  parameter int HALF_A   = 15944,
  parameter int HALF_B   = 11945,
  parameter int HALF_C   = 9480,
  parameter int TONE_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ovr_spd,
  input  logic       batt_low,
  input  logic       moving,
  output logic       audio_o,
  output logic       audio_o_n,
  output logic       busy,
  output logic [1:0] mode
);

  localparam int SW = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;

  logic [1:0]        req_mode;
  logic              batt_eff;
  logic [SW-1:0]     step_cnt, step_cnt_n;
  logic [1:0]        step_idx, step_idx_n;
  logic [TONE_W-1:0] tone_cnt, tone_cnt_n;
  logic              phase, phase_n;
  logic [TONE_W-1:0] half_cur;
  logic              tone_on_n;

`ifdef PIEZO_BATT_LATCH_EN
  // Sticky flag; OR-ing the live input lets the first pulse cycle take effect at once.
  logic batt_flag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) batt_flag <= 1'b0;
    else        batt_flag <= batt_flag | batt_low;
  end
  assign batt_eff = batt_low | batt_flag;
`else
  assign batt_eff = batt_low;
`endif

  // Half-period for a (mode, step) pair; zero means the step is silent.
  function automatic logic [TONE_W-1:0] half_sel(input logic [1:0] m, input logic [1:0] s);
    half_sel = '0;
    case (m)
      2'd3: half_sel = s[0] ? TONE_W'(HALF_B) : TONE_W'(HALF_A);
      2'd2: half_sel = s[0] ? '0 : TONE_W'(HALF_C);
      2'd1: begin
        case (s)
          2'd0:    half_sel = TONE_W'(HALF_A);
          2'd1:    half_sel = TONE_W'(HALF_B);
          2'd2:    half_sel = TONE_W'(HALF_C);
          default: half_sel = '0;
        endcase
      end
      default: half_sel = '0;
    endcase
  endfunction

  always_comb begin
    req_mode   = 2'd0;
    if (ovr_spd)       req_mode = 2'd3;
    else if (batt_eff) req_mode = 2'd2;
    else if (moving)   req_mode = 2'd1;

    half_cur   = half_sel(mode, step_idx);
    step_cnt_n = step_cnt + SW'(1);
    step_idx_n = step_idx;
    tone_cnt_n = tone_cnt + TONE_W'(1);
    phase_n    = phase;

    if (req_mode != mode) begin
      step_cnt_n = '0;
      step_idx_n = 2'd0;
      tone_cnt_n = '0;
      phase_n    = 1'b0;
    end else if (step_cnt == SW'(NOTE_CYC - 1)) begin
      step_cnt_n = '0;
      step_idx_n = step_idx + 2'd1;
      tone_cnt_n = '0;
      phase_n    = 1'b0;
    end else if (half_cur == '0) begin
      tone_cnt_n = '0;
      phase_n    = 1'b0;
    end else if (tone_cnt == half_cur - TONE_W'(1)) begin
      tone_cnt_n = '0;
      phase_n    = ~phase;
    end

    // Outputs are registered from next-state so audio lines up with mode/step.
    tone_on_n = (half_sel(req_mode, step_idx_n) != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= 2'd0;
      busy      <= 1'b0;
      step_cnt  <= '0;
      step_idx  <= 2'd0;
      tone_cnt  <= '0;
      phase     <= 1'b0;
      audio_o   <= 1'b0;
      audio_o_n <= 1'b0;
    end else begin
      mode      <= req_mode;
      busy      <= (req_mode != 2'd0);
      step_cnt  <= step_cnt_n;
      step_idx  <= step_idx_n;
      tone_cnt  <= tone_cnt_n;
      phase     <= phase_n;
      audio_o   <= tone_on_n & phase_n;
      audio_o_n <= tone_on_n & ~phase_n;
    end
  end

endmodule

// File: tb/tb_piezo_seq.sv
// Bench for piezo_seq: directed scenarios plus random request segments against a
// time-since-mode-change reference model.
module tb_piezo_seq;
  localparam int NC = 16, HA = 2, HB = 3, HC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ovr_spd = 1'b0, batt_low = 1'b0, moving = 1'b0;
  logic       audio_o, audio_o_n, busy;
  logic [1:0] mode;

  piezo_seq #(.NOTE_CYC(NC), .HALF_A(HA), .HALF_B(HB), .HALF_C(HC), .TONE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ovr_spd(ovr_spd), .batt_low(batt_low), .moving(moving),
    .audio_o(audio_o), .audio_o_n(audio_o_n), .busy(busy), .mode(mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ref_mode = 0;
  int t = 0;
  bit flag = 1'b0;

  function automatic int half_of(input int m, input int s);
    int tbl [4][4] = '{'{0, 0, 0, 0}, '{HA, HB, HC, 0}, '{HC, 0, HC, 0}, '{HA, HB, HA, HB}};
    return tbl[m][s];
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d rmode=%0d: observed %0d expected %0d", tag, t, ref_mode, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int s, w, h;
    logic ea, en;
    s = (t / NC) % 4;
    w = t % NC;
    h = half_of(ref_mode, s);
    if (h == 0) begin
      ea = 1'b0; en = 1'b0;
    end else begin
      ea = ((w / h) % 2) == 1;
      en = !ea;
    end
    chk("mode", mode, 2'(ref_mode));
    chk("busy", {1'b0, busy}, {1'b0, ref_mode != 0});
    chk("audio_o", {1'b0, audio_o}, {1'b0, ea});
    chk("audio_o_n", {1'b0, audio_o_n}, {1'b0, en});
  endtask

  task automatic cyc();
    int req;
    bit bl;
    @(posedge clk);
    if (!rst_n) begin
      ref_mode = 0; t = 0; flag = 1'b0;
    end else begin
`ifdef PIEZO_BATT_LATCH_EN
      bl = batt_low | flag;
`else
      bl = batt_low;
`endif
      req = ovr_spd ? 3 : bl ? 2 : moving ? 1 : 0;
      if (req != ref_mode) begin
        ref_mode = req; t = 0;
      end else t++;
      flag = flag | batt_low;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_req(input logic o, input logic b, input logic m);
    ovr_spd = o; batt_low = b; moving = m;
  endtask

  initial begin
    #1;
    chk("rst_audio", {audio_o, audio_o_n}, 2'b00);
    chk("rst_mode", mode, 2'd0);
    run(3);
    rst_n = 1'b1;
    run(100);

    // moving tone: A,B,C,silent repeating
    set_req(0, 0, 1);
    run(140);

    // over-speed arrives mid-step 2 of the moving pattern
    for (int i = 0; i < 200 && !(ref_mode == 1 && t % 64 == 40); i++) cyc();
    chk("reach_step2", 2'(ref_mode == 1 && t % 64 == 40), 2'd1);
    set_req(1, 0, 1);
    run(80);

    // battery low: C,silent repeating
    set_req(0, 1, 0);
    run(90);
    set_req(0, 0, 0);
    run(10);

    // asynchronous reset mid-tone
    set_req(1, 0, 0);
    run(21);
    #2 rst_n = 1'b0;
    #1;
    chk("async_audio", {audio_o, audio_o_n}, 2'b00);
    chk("async_mode", {busy, 1'b0}, 2'b00);
    chk("async_mode2", mode, 2'd0);
    run(2);
    rst_n = 1'b1;
    run(70);

    // single-cycle battery pulse after a fresh reset
    set_req(0, 0, 0);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(3);
    batt_low = 1'b1;
    cyc();
    batt_low = 1'b0;
    run(10);

    // random request segments, some one cycle long
    for (int k = 0; k < 40; k++) begin
      set_req(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      run((k % 4 == 0) ? 1 : int'($urandom_range(1, 70)));
      if (k == 20) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
